control_unit: RTL and testbench
===============================

# control_unit

Multicycle Moore controller that sequences the 16-bit unified-memory datapath. It consumes `opcode` (IR[15:12]) and `zero` (rs==0) from the datapath. It drives every datapath load, write, mux-select and ALUOp control, one state per cycle, from fetch through write-back. It also exposes halt/illegal status and a retired-instruction counter for the testbench.

## Interface
- `RST_VEC`, default 0: state entered on reset (S_RST); fixed, not to be overridden.
- `clk` in 1: clock, rising-edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 4: IR[15:12] from datapath.
- `zero` in 1: rf[rs]==0 from datapath; valid from ID onward.
- `IRload`, `Aload`, `Bload`, `ALUOutLoad`, `MDRload`, `RegWrite` out 1 each: datapath register enables.
- `MemRead`, `MemWrite`, `MemToReg`, `AddrSel`, `PCWrite` out 1 each: memory/PC controls.
- `ALUSrcA` out 2: 00 PC, 01 A, 10 zero.
- `ALUSrcB` out 2: 00 B, 01 +1, 10 imm16, 11 zero.
- `ALUOp` out 3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- `PCSel` out 2: 00/01 ALUOut, 10 jump target.
- `halted` out 1: high while in S_HALT.
- `illegal` out 1: sticky; set on any opcode B–E.
- `instr_count` out 16: retired instructions, wraps.
- `state` out 4: current state, debug.

## Operation
- ISA: 0–4 R-type rd←rs op rt with ALUOp=opcode[2:0]; 5 ADDI rd←rs+imm; 6 LI rd←imm; 7 LW rd←mem[rs+imm]; 8 SW mem[rs]←rt; 9 BEQZ rs, PC←PC+1+imm if rf[rs]==0; A JMP PC←IR[11:0]; F HALT; B–E illegal, executed as NOP.
- Outputs are a pure decode of `state`. Every output not listed for a state is 0.
- State encoding and outputs:
  - 0 S_RST: all 0 → IF1.
  - 1 IF1: MemRead, AddrSel=0, ALUSrcA=00, ALUSrcB=01, ADD, ALUOutLoad → IF2.
  - 2 IF2: MemRead, AddrSel=0, IRload, PCWrite, PCSel=00 → ID.
  - 3 ID: Aload, Bload, ALUSrcA=00, ALUSrcB=10, ADD, ALUOutLoad (branch target).
    - Next state by opcode: 0–4 EX_ALU; 5 EX_IMM; 6 EX_LI; 7 EX_LW; 8 EX_SW; 9 BR; F HALT.
    - JMP: ID additionally asserts PCWrite, PCSel=10 → IF1.
    - B–E → IF1.
  - 4 EX_ALU: ALUSrcA=01, ALUSrcB=00, ALUOp=opcode[2:0], ALUOutLoad → WB_ALU.
  - 5 EX_IMM: 01/10, ADD, ALUOutLoad → WB_ALU.
  - 6 EX_LI: 10/10, ADD, ALUOutLoad → WB_ALU.
  - 7 EX_LW: 01/10, ADD, ALUOutLoad → MEM_RD.
  - 15 EX_SW: 01/11, ADD, ALUOutLoad → MEM_WR.
  - 8 WB_ALU: RegWrite, MemToReg=0 → IF1.
  - 9 MEM_RD: MemRead, AddrSel=1 → MEM_WAIT.
  - 10 MEM_WAIT: MemRead, AddrSel=1, MDRload → WB_MEM.
  - 11 WB_MEM: RegWrite, MemToReg=1 → IF1.
  - 12 MEM_WR: MemWrite, AddrSel=1 → IF1.
  - 13 BR: PCWrite=`zero`, PCSel=01 → IF1.
  - 14 S_HALT: all 0, `halted`=1; stays until reset.
- `instr_count` increments on every edge that leaves a final state into IF1 or S_HALT: WB_ALU, WB_MEM, MEM_WR, BR, and ID for JMP/illegal/HALT. It wraps FFFF→0000. It does not increment on S_RST→IF1.
- `illegal` sets on the ID edge for opcode B–E and is cleared only by reset.
- imm8 = IR[7:0] shares bits with rs/rt. Encoding legality is the assembler's responsibility; the control unit does not check it.

## Timing
- Reset (async, any state, including mid-instruction): state=S_RST, all control outputs 0, `halted`=0, `illegal`=0, `instr_count`=0. First fetch (IF1) is the first cycle after reset deasserts.
- Memory read is synchronous: address is presented in IF1/MEM_RD, and data is captured in IF2/MEM_WAIT with MemRead held.
- Cycles per instruction:
  - R-type, ADDI, LI, SW: 5.
  - LW: 7.
  - BEQZ: 4, taken or not.
  - JMP and illegal: 3.
  - HALT: 3, then idle.
- `zero` is sampled only in BR. Its value in any other state is ignored.
- `opcode` is sampled only in ID; IR is stable from end of IF2.

## Test plan
- Reset release → state 1,2,3 on consecutive cycles; in IF1 MemRead=1, ALUSrcB=01, ALUOutLoad=1; in IF2 IRload=1, PCWrite=1, PCSel=00.
- opcode=1 (SUB) → states 1,2,3,4,8; ALUOp=1 in state 4; RegWrite=1, MemToReg=0 in state 8; `instr_count` 0→1.
- opcode=7 (LW) → 1,2,3,7,9,10,11; AddrSel=1 in 9 and 10; MDRload only in 10; MemToReg=1, RegWrite=1 in 11; 7 cycles.
- opcode=9 with zero=1 → PCWrite=1, PCSel=01 in BR; repeat with zero=0 → PCWrite=0; both return to IF1 after 4 cycles.
- opcode=A → PCWrite=1, PCSel=10 in ID, then IF1; opcode=C → `illegal`=1, next state IF1, count +1; opcode=F → `halted`=1, state 14 held 20 cycles, all controls 0.
- Reset asserted during MEM_WAIT → outputs 0 immediately, `instr_count`=0; preload count to FFFF via 65535 ops → next retire gives 0000.

Source files
------------

// File: rtl/control_unit.sv
// Multicycle Moore controller for the 16-bit unified-memory datapath.
// Sequences fetch/decode/execute/memory/write-back one state per cycle and
// drives every datapath enable, write, mux select and ALU operation.
module control_unit #(
   parameter int RST_VEC = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  opcode,
   input  logic        zero,
   output logic        IRload,
   output logic        Aload,
   output logic        Bload,
   output logic        ALUOutLoad,
   output logic        MDRload,
   output logic        RegWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        MemToReg,
   output logic        AddrSel,
   output logic        PCWrite,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [2:0]  ALUOp,
   output logic [1:0]  PCSel,
   output logic        halted,
   output logic        illegal,
   output logic [15:0] instr_count,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      IF1      = 4'd1,
      IF2      = 4'd2,
      ID       = 4'd3,
      EX_ALU   = 4'd4,
      EX_IMM   = 4'd5,
      EX_LI    = 4'd6,
      EX_LW    = 4'd7,
      WB_ALU   = 4'd8,
      MEM_RD   = 4'd9,
      MEM_WAIT = 4'd10,
      WB_MEM   = 4'd11,
      MEM_WR   = 4'd12,
      BR       = 4'd13,
      S_HALT   = 4'd14,
      EX_SW    = 4'd15
   } state_t;

   // ALU operand select encodings
   localparam logic [1:0] SRCA_PC   = 2'b00;
   localparam logic [1:0] SRCA_A    = 2'b01;
   localparam logic [1:0] SRCA_ZERO = 2'b10;
   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_ZERO = 2'b11;
   localparam logic [2:0] OP_ADD    = 3'd0;

   state_t cur, nxt;
   logic   op_illegal;
   logic   retire;

   assign state      = cur;
   assign op_illegal = (opcode inside {[4'hB:4'hE]});

   // State register; reset may land in any state, including mid-instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur <= state_t'(RST_VEC[3:0]);
      else       cur <= nxt;
   end

   // Next-state and control decode; everything not named for a state stays 0
   always_comb begin
      nxt        = cur;
      IRload     = 1'b0;
      Aload      = 1'b0;
      Bload      = 1'b0;
      ALUOutLoad = 1'b0;
      MDRload    = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemToReg   = 1'b0;
      AddrSel    = 1'b0;
      PCWrite    = 1'b0;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_B;
      ALUOp      = OP_ADD;
      PCSel      = 2'b00;
      halted     = 1'b0;
      case (cur)
         S_RST: nxt = IF1;
         IF1: begin
            // address PC into memory, compute PC+1 in parallel
            MemRead    = 1'b1;
            ALUSrcA    = SRCA_PC;
            ALUSrcB    = SRCB_ONE;
            ALUOutLoad = 1'b1;
            nxt        = IF2;
         end
         IF2: begin
            // synchronous read data lands in IR; PC takes PC+1
            MemRead = 1'b1;
            IRload  = 1'b1;
            PCWrite = 1'b1;
            PCSel   = 2'b00;
            nxt     = ID;
         end
         ID: begin
            // read operands and speculatively form the branch target
            Aload      = 1'b1;
            Bload      = 1'b1;
            ALUSrcA    = SRCA_PC;
            ALUSrcB    = SRCB_IMM;
            ALUOutLoad = 1'b1;
            case (opcode)
               4'h0, 4'h1, 4'h2, 4'h3, 4'h4: nxt = EX_ALU;
               4'h5: nxt = EX_IMM;
               4'h6: nxt = EX_LI;
               4'h7: nxt = EX_LW;
               4'h8: nxt = EX_SW;
               4'h9: nxt = BR;
               4'hA: begin
                  PCWrite = 1'b1;
                  PCSel   = 2'b10;
                  nxt     = IF1;
               end
               4'hF:    nxt = S_HALT;
               default: nxt = IF1;   // B-E retire as NOP
            endcase
         end
         EX_ALU: begin
            ALUSrcA    = SRCA_A;
            ALUSrcB    = SRCB_B;
            ALUOp      = opcode[2:0];
            ALUOutLoad = 1'b1;
            nxt        = WB_ALU;
         end
         EX_IMM: begin
            ALUSrcA    = SRCA_A;
            ALUSrcB    = SRCB_IMM;
            ALUOutLoad = 1'b1;
            nxt        = WB_ALU;
         end
         EX_LI: begin
            ALUSrcA    = SRCA_ZERO;
            ALUSrcB    = SRCB_IMM;
            ALUOutLoad = 1'b1;
            nxt        = WB_ALU;
         end
         EX_LW: begin
            ALUSrcA    = SRCA_A;
            ALUSrcB    = SRCB_IMM;
            ALUOutLoad = 1'b1;
            nxt        = MEM_RD;
         end
         EX_SW: begin
            // store address is rs itself: A + 0
            ALUSrcA    = SRCA_A;
            ALUSrcB    = SRCB_ZERO;
            ALUOutLoad = 1'b1;
            nxt        = MEM_WR;
         end
         WB_ALU: begin
            RegWrite = 1'b1;
            nxt      = IF1;
         end
         MEM_RD: begin
            MemRead = 1'b1;
            AddrSel = 1'b1;
            nxt     = MEM_WAIT;
         end
         MEM_WAIT: begin
            MemRead = 1'b1;
            AddrSel = 1'b1;
            MDRload = 1'b1;
            nxt     = WB_MEM;
         end
         WB_MEM: begin
            RegWrite = 1'b1;
            MemToReg = 1'b1;
            nxt      = IF1;
         end
         MEM_WR: begin
            MemWrite = 1'b1;
            AddrSel  = 1'b1;
            nxt      = IF1;
         end
         BR: begin
            // target already in ALUOut from ID; commit only if rs==0
            PCWrite = zero;
            PCSel   = 2'b01;
            nxt     = IF1;
         end
         S_HALT: begin
            halted = 1'b1;
            nxt    = S_HALT;
         end
         default: nxt = S_RST;
      endcase
   end

   // An instruction retires on the edge leaving its final state
   always_comb begin
      retire = 1'b0;
      case (cur)
         WB_ALU, WB_MEM, MEM_WR, BR: retire = 1'b1;
         ID:      retire = (opcode >= 4'hA);
         default: retire = 1'b0;
      endcase
   end

   // Retired-instruction counter, free-running wrap
   always_ff @(posedge clk or posedge reset) begin
      if (reset) instr_count <= 16'h0000;
      else       instr_count <= instr_count + {15'd0, retire};
   end

   // Sticky illegal-opcode flag, cleared only by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                         illegal <= 1'b0;
      else if (cur == ID && op_illegal)  illegal <= 1'b1;
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction-level model compared
// every cycle, plus directed literal checks of CPI, counts and flags.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  opcode = 4'h0;
   logic        zero = 1'b0;
   logic        IRload, Aload, Bload, ALUOutLoad, MDRload, RegWrite;
   logic        MemRead, MemWrite, MemToReg, AddrSel, PCWrite;
   logic [1:0]  ALUSrcA, ALUSrcB, PCSel;
   logic [2:0]  ALUOp;
   logic        halted, illegal;
   logic [15:0] instr_count;
   logic [3:0]  state;

   control_unit dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
      .IRload(IRload), .Aload(Aload), .Bload(Bload), .ALUOutLoad(ALUOutLoad),
      .MDRload(MDRload), .RegWrite(RegWrite), .MemRead(MemRead),
      .MemWrite(MemWrite), .MemToReg(MemToReg), .AddrSel(AddrSel),
      .PCWrite(PCWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSel(PCSel), .halted(halted), .illegal(illegal),
      .instr_count(instr_count), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       irload, aload, bload, aluoutload, mdrload, regwrite;
      logic       memread, memwrite, memtoreg, addrsel, pcwrite;
      logic [1:0] srca, srcb;
      logic [2:0] aluop;
      logic [1:0] pcsel;
      logic       halted;
   } ctl_t;

   typedef int iq_t[$];

   ctl_t act_ctl;
   assign act_ctl = {IRload, Aload, Bload, ALUOutLoad, MDRload, RegWrite,
                     MemRead, MemWrite, MemToReg, AddrSel, PCWrite,
                     ALUSrcA, ALUSrcB, ALUOp, PCSel, halted};

   int n_cmp = 0;
   int n_bad = 0;
   logic preload_req = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Control word the table dictates for each state
   function automatic ctl_t exp_ctl(input int st, input logic [3:0] op, input logic z);
      ctl_t c = '0;
      case (st)
         1:  begin c.memread = 1; c.srcb = 2'b01; c.aluoutload = 1; end
         2:  begin c.memread = 1; c.irload = 1; c.pcwrite = 1; end
         3:  begin
                c.aload = 1; c.bload = 1; c.srcb = 2'b10; c.aluoutload = 1;
                if (op == 4'hA) begin c.pcwrite = 1; c.pcsel = 2'b10; end
             end
         4:  begin c.srca = 2'b01; c.aluop = op[2:0]; c.aluoutload = 1; end
         5:  begin c.srca = 2'b01; c.srcb = 2'b10; c.aluoutload = 1; end
         6:  begin c.srca = 2'b10; c.srcb = 2'b10; c.aluoutload = 1; end
         7:  begin c.srca = 2'b01; c.srcb = 2'b10; c.aluoutload = 1; end
         15: begin c.srca = 2'b01; c.srcb = 2'b11; c.aluoutload = 1; end
         8:  c.regwrite = 1;
         9:  begin c.memread = 1; c.addrsel = 1; end
         10: begin c.memread = 1; c.addrsel = 1; c.mdrload = 1; end
         11: begin c.regwrite = 1; c.memtoreg = 1; end
         12: begin c.memwrite = 1; c.addrsel = 1; end
         13: begin c.pcwrite = z; c.pcsel = 2'b01; end
         14: c.halted = 1;
         default: c = '0;
      endcase
      return c;
   endfunction

   // States an instruction visits after IF1, ending with its final state
   function automatic iq_t seq_tail(input logic [3:0] op);
      iq_t q;
      q = {};
      q.push_back(2);
      q.push_back(3);
      if (op <= 4'h4) begin q.push_back(4); q.push_back(8); end
      else if (op == 4'h5) begin q.push_back(5); q.push_back(8); end
      else if (op == 4'h6) begin q.push_back(6); q.push_back(8); end
      else if (op == 4'h7) begin q.push_back(7); q.push_back(9); q.push_back(10); q.push_back(11); end
      else if (op == 4'h8) begin q.push_back(15); q.push_back(12); end
      else if (op == 4'h9) q.push_back(13);
      return q;
   endfunction

   // Model + compare, once per cycle on the falling edge
   int          m_state = 0;
   logic [15:0] m_count = 16'h0;
   logic        m_ill = 1'b0;
   logic [3:0]  m_op = 4'h0;
   iq_t         pend;

   initial forever begin
      @(negedge clk);
      if (reset) begin
         m_state = 0; m_count = 16'h0; m_ill = 1'b0; pend = {};
      end
      if (preload_req) m_count = 16'hFFFF;
      if (m_state == 1) m_op = opcode;
      check("state", 32'(state), 32'(m_state));
      check("ctl", 32'(act_ctl), 32'(exp_ctl(m_state, m_op, zero)));
      check("count", 32'(instr_count), 32'(m_count));
      check("illegal", 32'(illegal), 32'(m_ill));
      if (!reset) begin
         if (m_state == 0) m_state = 1;
         else if (m_state != 14) begin
            if (m_state == 1) pend = seq_tail(m_op);
            if (pend.size() > 0) m_state = pend.pop_front();
            else begin
               m_count = m_count + 16'd1;
               if (m_op inside {[4'hB:4'hE]}) m_ill = 1'b1;
               m_state = (m_op == 4'hF) ? 14 : 1;
            end
         end
      end
   end

   // Issue one instruction from IF1 and check where it lands
   task automatic run(input logic [3:0] op, input logic z, input int cyc,
                      input int st_after, input logic [15:0] cnt_after);
      opcode = op;
      zero   = z;
      repeat (cyc) @(posedge clk);
      #2;
      check("cpi_state", 32'(state), 32'(st_after));
      check("cpi_count", 32'(instr_count), 32'(cnt_after));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      @(posedge clk); #2;
      check("first_fetch", 32'(state), 32'd1);
      check("reset_count", 32'(instr_count), 32'd0);

      run(4'h1, 1'b1, 5, 1, 16'd1);     // SUB
      run(4'h7, 1'b0, 7, 1, 16'd2);     // LW
      // BEQZ taken
      opcode = 4'h9; zero = 1'b1;
      repeat (3) @(posedge clk); #2;
      check("br_taken_pcw", 32'({PCWrite, PCSel}), 32'b101);
      @(posedge clk); #2;
      check("br_taken_end", 32'(state), 32'd1);
      // BEQZ not taken
      opcode = 4'h9; zero = 1'b0;
      repeat (3) @(posedge clk); #2;
      check("br_nt_pcw", 32'({PCWrite, PCSel}), 32'b001);
      @(posedge clk); #2;
      check("br_nt_count", 32'(instr_count), 32'd4);

      run(4'h0, 1'b0, 5, 1, 16'd5);
      run(4'h2, 1'b1, 5, 1, 16'd6);
      run(4'h3, 1'b0, 5, 1, 16'd7);
      run(4'h4, 1'b1, 5, 1, 16'd8);
      run(4'h5, 1'b0, 5, 1, 16'd9);
      run(4'h6, 1'b1, 5, 1, 16'd10);
      run(4'h8, 1'b0, 5, 1, 16'd11);
      run(4'hA, 1'b1, 3, 1, 16'd12);    // JMP
      check("no_illegal_yet", 32'(illegal), 32'd0);
      run(4'hC, 1'b0, 3, 1, 16'd13);
      check("illegal_set", 32'(illegal), 32'd1);
      run(4'hB, 1'b0, 3, 1, 16'd14);
      run(4'hD, 1'b1, 3, 1, 16'd15);
      run(4'hE, 1'b0, 3, 1, 16'd16);

      // Async reset landing in MEM_WAIT
      opcode = 4'h7; zero = 1'b0;
      repeat (5) @(posedge clk); #2;
      check("in_mem_wait", 32'(state), 32'd10);
      check("mdrload_wait", 32'({MDRload, AddrSel, MemRead}), 32'b111);
      #1 reset = 1'b1;
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_ctl", 32'(act_ctl), 32'd0);
      check("rst_count", 32'(instr_count), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      @(posedge clk); #2 reset = 1'b0;
      @(posedge clk); #2;
      check("refetch", 32'(state), 32'd1);

      // Counter wrap: park the count at FFFF during IF1, then retire an LI
      opcode = 4'h6; zero = 1'b0;
      force dut.instr_count = 16'hFFFF;
      preload_req = 1'b1;
      @(posedge clk); #2;
      release dut.instr_count;
      preload_req = 1'b0;
      check("preload", 32'(instr_count), 32'hFFFF);
      repeat (4) @(posedge clk); #2;
      check("wrap_state", 32'(state), 32'd1);
      check("wrap_count", 32'(instr_count), 32'd0);

      // HALT and idle
      run(4'hF, 1'b1, 3, 14, 16'd1);
      repeat (20) @(posedge clk); #2;
      check("halt_state", 32'(state), 32'd14);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_ctl", 32'(act_ctl), 32'd1);
      check("halt_count", 32'(instr_count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
